// File: rtl/vc_pkg.sv
// -----------------------------------------------------------------------------
// vc_pkg
// Shared definitions for the Voice Corruptor sample-rate path. The tick
// generator and tick_period_monitor both take their rate from here, so the
// expected tick interval is defined in exactly one place.
//
// Contents:
//   VC_N_PERIOD    expected clocks between ticks (generator reload + 1)
//   VC_TOL         allowed deviation either side of VC_N_PERIOD
//   VC_LOCK_COUNT  consecutive good intervals needed to declare lock
//   VC_CNT_W       interval counter / period width
//   mon_state_e    tick_period_monitor FSM states
// -----------------------------------------------------------------------------
package vc_pkg;

  localparam int unsigned VC_N_PERIOD   = 655;
  localparam int unsigned VC_TOL        = 2;
  localparam int unsigned VC_LOCK_COUNT = 4;
  localparam int unsigned VC_CNT_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // disabled, everything cleared
    ST_ARMED  = 2'd1,  // enabled, waiting for a reference tick
    ST_SEARCH = 2'd2,  // measuring, not yet stable
    ST_LOCKED = 2'd3   // measuring, rate stable
  } mon_state_e;

endpackage : vc_pkg

// File: rtl/tick_period_monitor_if.sv
// -----------------------------------------------------------------------------
// tick_period_monitor_if
// Bundles the tick input and the measurement/status outputs of
// tick_period_monitor. Clock and reset stay outside as plain ports.
//
// Signals:
//   en            monitor enable (low forces the monitor idle)
//   tick          one-cycle strobe from the tick generator
//   period        last measured interval in clocks
//   period_valid  one-cycle pulse: period updated
//   locked        level: tick rate stable
//   err           one-cycle pulse: early tick
//   missing       one-cycle pulse: no tick within N_PERIOD+TOL clocks
//
// Modports:
//   master  the side that drives en/tick and consumes status (FSM / bench)
//   slave   the monitor itself
// -----------------------------------------------------------------------------
interface tick_period_monitor_if
  import vc_pkg::*;
#(
  parameter int CNT_W = VC_CNT_W
);

  logic             en;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             err;
  logic             missing;

  modport master (
    output en,
    output tick,
    input  period,
    input  period_valid,
    input  locked,
    input  err,
    input  missing
  );

  modport slave (
    input  en,
    input  tick,
    output period,
    output period_valid,
    output locked,
    output err,
    output missing
  );

endinterface : tick_period_monitor_if

// File: rtl/tick_interval_counter.sv
// -----------------------------------------------------------------------------
// tick_interval_counter
// Saturating up-counter measuring clocks since the last accepted tick.
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset (count to 0)
//   clr_i   synchronous clear to 0 (wins over load_i)
//   load_i  synchronous load of 1 (a tick is accepted this cycle)
//   cnt_o   current count; holds at all-ones once saturated
// -----------------------------------------------------------------------------
module tick_interval_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Loading 1 (not 0) on a tick makes the count on the next tick equal the
  // full interval: ticks 655 clocks apart read back 655.
  always_comb begin
    // NOTE: assign a default first so every path drives cnt_d; a missing
    // branch in always_comb would otherwise infer a latch.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : tick_interval_counter

// File: rtl/tick_period_monitor.sv
// -----------------------------------------------------------------------------
// tick_period_monitor
// Receive-side checker for the sample-rate strobe. Measures the interval
// between ticks, reports each measured period, declares lock after
// LOCK_COUNT consecutive in-window intervals, and flags early ticks (err)
// and absent ticks (missing). All outputs are registered.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset (wins over bus.en)
//   bus   tick_period_monitor_if.slave: en, tick in; period, period_valid,
//         locked, err, missing out
// -----------------------------------------------------------------------------
module tick_period_monitor
  import vc_pkg::*;
#(
  parameter int N_PERIOD   = VC_N_PERIOD,
  parameter int TOL        = VC_TOL,
  parameter int LOCK_COUNT = VC_LOCK_COUNT,
  parameter int CNT_W      = VC_CNT_W
) (
  input logic                  clk,
  input logic                  rst,
  tick_period_monitor_if.slave bus
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  WIN_LO      = CNT_W'(N_PERIOD - TOL);
  localparam logic [CNT_W-1:0]  WIN_HI      = CNT_W'(N_PERIOD + TOL);
  localparam logic [GOOD_W-1:0] LOCK_TARGET = GOOD_W'(LOCK_COUNT);

  mon_state_e        state_q;
  logic [GOOD_W-1:0] good_q;
  logic [CNT_W-1:0]  period_q;
  logic              period_valid_q;
  logic              locked_q;
  logic              err_q;
  logic              missing_q;

  logic [CNT_W-1:0]  cnt;
  logic              cnt_clr;
  logic              cnt_load;
  logic              in_window;
  logic [GOOD_W-1:0] good_inc;

  always_comb begin
    // Counter sits at 0 while disabled/idle; a tick reloads it only once the
    // monitor has left IDLE, so the tick in the IDLE->ARMED cycle is ignored.
    cnt_clr   = !bus.en || (state_q == ST_IDLE);
    cnt_load  = bus.en && bus.tick && (state_q != ST_IDLE);
    in_window = (cnt >= WIN_LO) && (cnt <= WIN_HI);
    good_inc  = good_q + GOOD_W'(1);
  end

  tick_interval_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .load_i (cnt_load),
    .cnt_o  (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      good_q         <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_q          <= 1'b0;
      missing_q      <= 1'b0;
    end else begin
      // Pulse outputs are high for exactly one cycle after the event.
      period_valid_q <= 1'b0;
      err_q          <= 1'b0;
      missing_q      <= 1'b0;

      if (!bus.en) begin
        state_q  <= ST_IDLE;
        good_q   <= '0;
        locked_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_q <= ST_ARMED;
          end

          ST_ARMED: begin
            // First tick only sets the reference point; nothing to report.
            if (bus.tick) begin
              state_q <= ST_SEARCH;
            end
          end

          ST_SEARCH, ST_LOCKED: begin
            if (bus.tick) begin
              period_q       <= cnt;
              period_valid_q <= 1'b1;
              if (in_window) begin
                if (state_q == ST_SEARCH) begin
                  good_q <= good_inc;
                  if (good_inc == LOCK_TARGET) begin
                    state_q  <= ST_LOCKED;
                    locked_q <= 1'b1;
                  end
                end
              end else begin
                // Only early ticks reach here: a late one is caught as
                // missing when cnt reaches WIN_HI.
                err_q    <= 1'b1;
                good_q   <= '0;
                locked_q <= 1'b0;
                state_q  <= ST_SEARCH;
              end
            end else if (cnt == WIN_HI) begin
              // A tick at exactly WIN_HI is good; one cycle later is too late.
              missing_q <= 1'b1;
              locked_q  <= 1'b0;
              good_q    <= '0;
              state_q   <= ST_ARMED;
            end
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.locked       = locked_q;
  assign bus.err          = err_q;
  assign bus.missing      = missing_q;

endmodule : tick_period_monitor
